// File: rtl/nrisc_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nrisc_mem_pkg
// Description : Shared definitions for the data-memory responder and the
//               core's load/store unit: default bus widths and the responder
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package nrisc_mem_pkg;

  // Bus widths shared with the load/store unit.
  localparam int unsigned MEM_ADDR_W = 8;
  localparam int unsigned MEM_DATA_W = 8;

  // Responder states: idle (accepting), wait states, response pending.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_array
// Description : DEPTH x DATA_W storage, synchronous write, combinational read.
//               Contents are not reset.
// Ports       : clk   - clock
//               we    - write enable (write on posedge)
//               addr  - word address (caller guarantees addr < DEPTH on write)
//               wdata - write data
//               rdata - read data at addr
// Revision    : 1.0 - initial release
// ============================================================================
module mem_array
  import nrisc_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int DEPTH  = 200
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Single-port data-memory responder. Accepts one load/store at
//               a time over valid/ready, waits WAIT cycles, performs the
//               access and returns data / acknowledge with an out-of-range
//               error flag.
// Ports       : clk, rst_n (sync, active-low)
//               req_valid/req_ready/req_we/req_addr/req_wdata - request
//               rsp_valid/rsp_ready/rsp_rdata/rsp_err         - response
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
  import nrisc_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int DEPTH  = 200,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam logic [3:0]      WAIT_INIT = 4'(WAIT);
  localparam bit              NO_WAIT   = (WAIT == 0);
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  mem_state_t        state;
  mem_state_t        state_next;
  logic [3:0]        cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              accept;
  logic              access;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_in_range;
  logic              arr_we;
  logic [DATA_W-1:0] arr_rdata;

  // With WAIT=0 the access happens on the accept edge itself, so the access
  // path takes the live request in IDLE and the latched copy otherwise.
  assign acc_we       = (state == S_IDLE) ? req_we    : lat_we;
  assign acc_addr     = (state == S_IDLE) ? req_addr  : lat_addr;
  assign acc_wdata    = (state == S_IDLE) ? req_wdata : lat_wdata;
  assign acc_in_range = ({1'b0, acc_addr} < DEPTH_LIM);

  // Reset gates the write so a store reaching its access edge while reset is
  // asserted is discarded.
  assign arr_we = access & acc_we & acc_in_range & rst_n;

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (acc_addr),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    access     = 1'b0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_rdata  = rdata_q;
    rsp_err    = err_q;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (NO_WAIT) begin
            access     = 1'b1;
            state_next = S_RESP;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Access on the edge where the counter goes 1 -> 0.
        if (cnt <= 4'd1) begin
          access     = 1'b1;
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        cnt       <= WAIT_INIT;
      end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        rdata_q <= (acc_we || !acc_in_range) ? '0 : arr_rdata;
        err_q   <= !acc_in_range;
      end else if ((state == S_RESP) && rsp_ready) begin
        // Read data is held until the next access; only the error clears.
        err_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Scoreboard bench for mem_responder. u0 runs with WAIT=2,
//               u1 with WAIT=0 for back-to-back streaming.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // u0 signals (WAIT=2)
  logic       req_valid0 = 1'b0, req_we0 = 1'b0, rsp_ready0 = 1'b1;
  logic [7:0] req_addr0 = '0, req_wdata0 = '0;
  logic       req_ready0, rsp_valid0, rsp_err0;
  logic [7:0] rsp_rdata0;

  // u1 signals (WAIT=0)
  logic       req_valid1 = 1'b0, req_we1 = 1'b0, rsp_ready1 = 1'b1;
  logic [7:0] req_addr1 = '0, req_wdata1 = '0;
  logic       req_ready1, rsp_valid1, rsp_err1;
  logic [7:0] rsp_rdata1;

  exp_t q0[$];
  exp_t q1[$];

  mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(200), .WAIT(2)) u0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(200), .WAIT(0)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
    .req_addr(req_addr1), .req_wdata(req_wdata1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // ---------------- u0 monitor ----------------
  bit   in_rsp0 = 1'b0;
  bit   exp_idle0 = 1'b0;
  exp_t cur0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_rsp0   = 1'b0;
      exp_idle0 = 1'b0;
    end else begin
      if (exp_idle0) begin
        chk("u0_idle_after_hs", req_ready0, 1);
        chk("u0_valid_clr", rsp_valid0, 0);
        chk("u0_err_clr", rsp_err0, 0);
        exp_idle0 = 1'b0;
      end
      if (rsp_valid0) begin
        if (!in_rsp0) begin
          if (q0.size() == 0) begin
            fail("u0_unexpected_rsp");
          end else begin
            cur0    = q0.pop_front();
            in_rsp0 = 1'b1;
            chk("u0_rdata", rsp_rdata0, cur0.rdata);
            chk("u0_err", rsp_err0, cur0.err);
            chk("u0_latency", cyc + 1 - cur0.acc, 3);
          end
        end else begin
          chk("u0_rdata_stable", rsp_rdata0, cur0.rdata);
          chk("u0_err_stable", rsp_err0, cur0.err);
          chk("u0_ready_low", req_ready0, 0);
        end
        if (rsp_ready0) begin
          in_rsp0   = 1'b0;
          exp_idle0 = 1'b1;
        end
      end
    end
  end

  // ---------------- u1 monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid1) begin
      if (q1.size() == 0) begin
        fail("u1_unexpected_rsp");
      end else begin
        e = q1.pop_front();
        chk("u1_rdata", rsp_rdata1, e.rdata);
        chk("u1_err", rsp_err1, e.err);
        chk("u1_latency", cyc + 1 - e.acc, 1);
      end
    end
  end

  // ---------------- u0 driver ----------------
  task automatic issue0(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                        input logic [7:0] exp_rd, input logic exp_err);
    int n = 0;
    @(negedge clk);
    req_we0 = we; req_addr0 = addr; req_wdata0 = wd; req_valid0 = 1'b1;
    while (!req_ready0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail("u0_accept_timeout");
    q0.push_back('{exp_rd, exp_err, cyc + 1});
    @(posedge clk);
    #1 req_valid0 = 1'b0;
  endtask

  task automatic wait_done0();
    int n = 0;
    @(negedge clk);
    while ((!req_ready0 || q0.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) fail("u0_done_timeout");
  endtask

  task automatic check_reset_outputs(input string nm);
    @(negedge clk);
    chk({nm, "_req_ready"}, req_ready0, 1);
    chk({nm, "_rsp_valid"}, rsp_valid0, 0);
    chk({nm, "_rsp_rdata"}, rsp_rdata0, 0);
    chk({nm, "_rsp_err"}, rsp_err0, 0);
  endtask

  // ---------------- u1 driver ----------------
  task automatic stream1();
    logic       v_we   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] v_addr [6] = '{8'd3, 8'd4, 8'd3, 8'd4, 8'd250, 8'd201};
    logic [7:0] v_wd   [6] = '{8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'hFF};
    logic [7:0] v_rd   [6] = '{8'h00, 8'h00, 8'h12, 8'h34, 8'h00, 8'h00};
    logic       v_err  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int last = -1;
    @(negedge clk);
    req_valid1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      int n = 0;
      req_we1 = v_we[i]; req_addr1 = v_addr[i]; req_wdata1 = v_wd[i];
      while (!req_ready1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) fail("u1_accept_timeout");
      q1.push_back('{v_rd[i], v_err[i], cyc + 1});
      if (last >= 0) chk("u1_accept_spacing", cyc + 1 - last, 2);
      last = cyc + 1;
      @(posedge clk);
      #1;
    end
    req_valid1 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    // Reset held with a request pending: nothing may be accepted.
    rst_n = 1'b0;
    req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 8'd7; req_wdata0 = 8'h99;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; req_valid0 = 1'b0;
    check_reset_outputs("rst");
    repeat (5) @(negedge clk);

    // Pre-writes
    issue0(1'b1, 8'd9,   8'h11, 8'h00, 1'b0); wait_done0();
    issue0(1'b1, 8'd10,  8'h22, 8'h00, 1'b0); wait_done0();
    issue0(1'b1, 8'd199, 8'h66, 8'h00, 1'b0); wait_done0();

    // Store then load
    issue0(1'b1, 8'd5, 8'hA7, 8'h00, 1'b0); wait_done0();
    issue0(1'b0, 8'd5, 8'h00, 8'hA7, 1'b0); wait_done0();

    // Backpressure
    rsp_ready0 = 1'b0;
    issue0(1'b0, 8'd199, 8'h00, 8'h66, 1'b0);
    n = 0;
    while (!rsp_valid0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) fail("u0_bp_rsp_timeout");
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 rsp_ready0 = 1'b1;
    wait_done0();

    // Out of range
    issue0(1'b1, 8'd200, 8'h55, 8'h00, 1'b1); wait_done0();
    issue0(1'b0, 8'd199, 8'h00, 8'h66, 1'b0); wait_done0();
    issue0(1'b0, 8'd255, 8'h00, 8'h00, 1'b1); wait_done0();

    // WAIT=0 back-to-back on u1
    stream1();

    // Load leaves non-zero read data held, so the reset clear is visible.
    issue0(1'b0, 8'd5, 8'h00, 8'hA7, 1'b0); wait_done0();

    // Reset in the first WAIT cycle of a store to addr 9.
    @(negedge clk);
    req_we0 = 1'b1; req_addr0 = 8'd9; req_wdata0 = 8'h3C; req_valid0 = 1'b1;
    @(posedge clk);
    #1 req_valid0 = 1'b0; rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_outputs("rst_wait1");
    issue0(1'b0, 8'd9, 8'h00, 8'h11, 1'b0); wait_done0();

    // Reset landing on the access edge of a store to addr 10.
    @(negedge clk);
    req_we0 = 1'b1; req_addr0 = 8'd10; req_wdata0 = 8'hC3; req_valid0 = 1'b1;
    @(posedge clk);
    #1 req_valid0 = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_outputs("rst_wait2");
    issue0(1'b0, 8'd10, 8'h00, 8'h22, 1'b0); wait_done0();

    repeat (5) @(negedge clk);
    chk("u0_queue_drained", q0.size(), 0);
    chk("u1_queue_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
